// File: rtl/fp_pkg.sv
// fp_pkg: constants, encodings and stage bundles shared by the FP converters.
// Integer-format codes double as the FP-to-integer converter's output select.
package fp_pkg;

    localparam int BIAS_D = 1023;
    localparam int BIAS_S = 127;
    localparam int MANT_D = 52;
    localparam int MANT_S = 23;

    localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    typedef enum logic [1:0] {
        IFMT_W  = 2'b00,
        IFMT_WU = 2'b01,
        IFMT_L  = 2'b10,
        IFMT_LU = 2'b11
    } int_fmt_e;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        fmt;
        logic [2:0]  rm;
        logic [63:0] mag;
    } cvt_s1_t;

    // norm drops the always-set leading one left after normalization
    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        fmt;
        logic [2:0]  rm;
        logic [5:0]  exp;
        logic [62:0] norm;
    } cvt_s2_t;

    // Reserved rounding modes fall through to round-to-nearest-even
    function automatic logic round_up(
        input logic [2:0] rm,
        input logic       sign,
        input logic       lsb,
        input logic       guard,
        input logic       sticky
    );
        logic nx;
        nx = guard | sticky;
        case (rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & nx;
            RM_RUP:  round_up = ~sign & nx;
            RM_RMM:  round_up = guard;
            default: round_up = guard & (sticky | lsb);
        endcase
    endfunction

endpackage

// File: rtl/lzc64.sv
// lzc64: combinational leading-zero counter for a 64-bit word.
// An all-zero word reports 64.
module lzc64 (
    input  logic [63:0] data,
    output logic [6:0]  count
);

    always_comb begin
        count = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (data[i]) begin
                count = 7'(63 - i);
            end
        end
    end

endmodule

// File: rtl/int_fp_convert_pipe.sv
// int_fp_convert_pipe: 3-stage integer to IEEE-754 single/double converter.
// S1 captures the magnitude, S2 normalizes, S3 rounds and packs.
module int_fp_convert_pipe
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_int_fmt,
    input  logic                  in_fmt,
    input  logic [2:0]            in_rm,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_flg_NX
);

    logic    s1_valid;
    logic    s2_valid;
    cvt_s1_t s1_d;
    cvt_s1_t s1_q;
    cvt_s2_t s2_d;
    cvt_s2_t s2_q;

    logic s3_ready;
    logic s2_ready;
    logic accept;

    assign s3_ready  = ~out_valid | in_ready;
    assign s2_ready  = ~s2_valid | s3_ready;
    assign out_ready = ~s1_valid | s2_ready;
    assign accept    = in_valid & out_ready;

    logic [63:0] op;
    logic        neg;

    always_comb begin
        op  = in_data;
        neg = 1'b0;
        unique case (in_int_fmt)
            IFMT_W: begin
                op  = {{32{in_data[31]}}, in_data[31:0]};
                neg = in_data[31];
            end
            IFMT_WU: op  = {32'd0, in_data[31:0]};
            IFMT_L:  neg = in_data[63];
            IFMT_LU: ;
        endcase
        s1_d.sign = neg;
        s1_d.mag  = neg ? (64'd0 - op) : op;
        s1_d.zero = (op == 64'd0);
        s1_d.fmt  = in_fmt;
        s1_d.rm   = in_rm;
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (out_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    logic [6:0] lz;

    lzc64 u_lzc (
        .data  (s1_q.mag),
        .count (lz)
    );

    always_comb begin
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.fmt  = s1_q.fmt;
        s2_d.rm   = s1_q.rm;
        s2_d.exp  = 6'(7'd63 - lz);
        s2_d.norm = 63'(s1_q.mag << lz);
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        inc;
    logic [52:0] frac_d;
    logic [23:0] frac_s;
    logic [10:0] exp_d;
    logic [7:0]  exp_s;
    logic [63:0] res;
    logic        nx;

    // A carry out of the fraction adder means 1.11..1 rounded to 10.00..0
    always_comb begin
        if (s2_q.fmt) begin
            lsb    = s2_q.norm[11];
            guard  = s2_q.norm[10];
            sticky = |s2_q.norm[9:0];
        end else begin
            lsb    = s2_q.norm[40];
            guard  = s2_q.norm[39];
            sticky = |s2_q.norm[38:0];
        end
        inc    = round_up(s2_q.rm, s2_q.sign, lsb, guard, sticky);
        frac_d = {1'b0, s2_q.norm[62:11]} + 53'(inc);
        frac_s = {1'b0, s2_q.norm[62:40]} + 24'(inc);
        exp_d  = 11'(s2_q.exp) + 11'(BIAS_D) + 11'(frac_d[MANT_D]);
        exp_s  = 8'(s2_q.exp) + 8'(BIAS_S) + 8'(frac_s[MANT_S]);
        nx     = guard | sticky;
        if (s2_q.zero) begin
            res = s2_q.fmt ? 64'd0 : {NAN_BOX, 32'd0};
            nx  = 1'b0;
        end else if (s2_q.fmt) begin
            res = {s2_q.sign, exp_d, frac_d[MANT_D-1:0]};
        end else begin
            res = {NAN_BOX, s2_q.sign, exp_s, frac_s[MANT_S-1:0]};
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_flg_NX <= 1'b0;
        end else if (s3_ready) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data   <= res;
                out_flg_NX <= nx;
            end
        end
    end

endmodule

// File: tb/tb_int_fp_convert_pipe.sv
// tb_int_fp_convert_pipe: directed and random checks of the converter
// against an arithmetic reference model.
module tb_int_fp_convert_pipe;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic [1:0]  in_int_fmt;
    logic        in_fmt;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_flg_NX;

    int vectors = 0;
    int miscompares = 0;

    always #5 in_clk = ~in_clk;

    int_fp_convert_pipe #(.DATA_WIDTH(64)) dut (
        .in_clk     (in_clk),
        .in_rst_n   (in_rst_n),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_data    (in_data),
        .in_int_fmt (in_int_fmt),
        .in_fmt     (in_fmt),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_flg_NX (out_flg_NX)
    );

    typedef struct {
        logic [63:0] d;
        logic [1:0]  f;
        logic        fm;
        logic [2:0]  rm;
        logic [63:0] res;
        logic        nx;
    } vec_t;

    // Reference: value = q * 2^sh + r, rounded by comparing r with half an ulp
    function automatic logic [64:0] ref_conv(
        input logic [63:0] d,
        input logic [1:0]  f,
        input logic        fm,
        input logic [2:0]  rm
    );
        longint signed v;
        logic neg, nx, up;
        logic [63:0] mag, q, r, half, one;
        int msb, p, sh, e;
        one = 64'd1;
        case (f)
            2'b00:   v = longint'($signed(d[31:0]));
            2'b01:   v = longint'({32'd0, d[31:0]});
            default: v = $signed(d);
        endcase
        neg = (v < 0);
        mag = neg ? 64'(-v) : 64'(v);
        if (f == 2'b11) begin
            neg = 1'b0;
            mag = d;
        end
        if (mag == 64'd0) begin
            return fm ? 65'd0 : {1'b0, 32'hFFFFFFFF, 32'd0};
        end
        msb = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
        p = fm ? 53 : 24;
        if (msb < p) begin
            q = mag << (p - 1 - msb);
            r = 64'd0;
            half = one;
        end else begin
            sh = msb - p + 1;
            q = mag >> sh;
            r = mag & ((one << sh) - one);
            half = one << (sh - 1);
        end
        nx = (r != 64'd0);
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = neg && nx;
            3'd3:    up = !neg && nx;
            3'd4:    up = nx && (r >= half);
            default: up = (r > half) || (nx && r == half && q[0]);
        endcase
        q = q + 64'(up);
        e = msb;
        if (q == (one << p)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (fm) return {nx, neg, 11'(e + 1023), q[51:0]};
        return {nx, 32'hFFFFFFFF, neg, 8'(e + 127), q[22:0]};
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] d;
        d = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: d = d >> $urandom_range(0, 63);
            1: d = 64'd0 - (d >> $urandom_range(1, 63));
            2: d = {d[63:32], 32'(d[31:0] >> $urandom_range(0, 31))};
            3: d = 64'(64'hFFFF_FFFF_FFFF_FFFF << $urandom_range(0, 63));
            default: ;
        endcase
        return d;
    endfunction

    // Issues one request into an empty pipe and waits for its result
    task automatic convert(
        input  logic [63:0] d,
        input  logic [1:0]  f,
        input  logic        fm,
        input  logic [2:0]  rm,
        output logic [63:0] res,
        output logic        nx,
        output int          lat
    );
        @(negedge in_clk);
        in_valid = 1'b1;
        in_data = d;
        in_int_fmt = f;
        in_fmt = fm;
        in_rm = rm;
        in_ready = 1'b1;
        @(posedge in_clk);
        @(negedge in_clk);
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
        in_int_fmt = 2'($urandom);
        in_fmt = 1'($urandom);
        in_rm = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge in_clk);
            lat++;
        end
        res = out_data;
        nx = out_flg_NX;
    endtask

    task automatic test_reset();
        in_rst_n = 1'b0;
        in_valid = 1'b1;
        in_ready = 1'b0;
        in_data = 64'd5;
        in_int_fmt = 2'b10;
        in_fmt = 1'b1;
        in_rm = 3'd0;
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_flg_NX !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b data=%h nx=%b, want 0/0/0",
                     out_valid, out_data, out_flg_NX);
        end
        in_valid = 1'b0;
        in_rst_n = 1'b1;
        @(negedge in_clk);
        vectors++;
        if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: ready=%b valid=%b, want 1/0",
                     out_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        vec_t tab[12];
        logic [63:0] res;
        logic nx;
        int lat;
        tab = '{
            '{64'd1, 2'b10, 1'b1, 3'd0, 64'h3FF0000000000000, 1'b0},
            '{64'hFFFFFFFF, 2'b00, 1'b0, 3'd0, 64'hFFFFFFFF_BF800000, 1'b0},
            '{64'hFFFFFFFF, 2'b00, 1'b0, 3'd0, 64'hFFFFFFFF_BF800000, 1'b0},
            '{64'd16777217, 2'b01, 1'b0, 3'd0, 64'hFFFFFFFF_4B800000, 1'b1},
            '{64'd16777217, 2'b01, 1'b0, 3'd3, 64'hFFFFFFFF_4B800001, 1'b1},
            '{64'd16777217, 2'b01, 1'b0, 3'd1, 64'hFFFFFFFF_4B800000, 1'b1},
            '{64'hFFFFFFFFFFFFFFFF, 2'b11, 1'b1, 3'd0, 64'h43F0000000000000, 1'b1},
            '{64'h8000000000000000, 2'b10, 1'b1, 3'd0, 64'hC3E0000000000000, 1'b0},
            '{64'd0, 2'b10, 1'b1, 3'd0, 64'd0, 1'b0},
            '{64'hFEFFFFFF, 2'b00, 1'b0, 3'd2, 64'hFFFFFFFF_CB800001, 1'b1},
            '{64'd16777219, 2'b01, 1'b0, 3'd7, 64'hFFFFFFFF_4B800002, 1'b1},
            '{64'd16777217, 2'b01, 1'b0, 3'd4, 64'hFFFFFFFF_4B800001, 1'b1}
        };
        tab[1].d[63:32] = $urandom;
        tab[2].d[63:32] = $urandom | 32'h1;
        for (int i = 0; i < 12; i++) begin
            convert(tab[i].d, tab[i].f, tab[i].fm, tab[i].rm, res, nx, lat);
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL dir%0d_latency: got %0d cycles, want 3", i, lat);
            end
            vectors++;
            if (res !== tab[i].res || nx !== tab[i].nx) begin
                miscompares++;
                $display("FAIL dir%0d_result: got %h nx=%b, want %h nx=%b",
                         i, res, nx, tab[i].res, tab[i].nx);
            end
        end
        @(negedge in_clk);
    endtask

    task automatic test_random();
        logic [64:0] sb[$];
        logic [64:0] exp_v;
        int cyc;
        sb.delete();
        cyc = 0;
        while (cyc < 400 || (sb.size() != 0 && cyc < 460)) begin
            @(negedge in_clk);
            in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
            in_data = rand_op();
            in_int_fmt = 2'($urandom);
            in_fmt = 1'($urandom);
            in_rm = 3'($urandom);
            in_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && out_ready) begin
                sb.push_back(ref_conv(in_data, in_int_fmt, in_fmt, in_rm));
            end
            if (out_valid && in_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: unexpected result %h", out_data);
                end else begin
                    exp_v = sb.pop_front();
                    if (out_data !== exp_v[63:0] || out_flg_NX !== exp_v[64]) begin
                        miscompares++;
                        $display("FAIL rand_result: got %h nx=%b, want %h nx=%b",
                                 out_data, out_flg_NX, exp_v[63:0], exp_v[64]);
                    end
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rand_drain: %0d results outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] sb[$];
        logic [64:0] exp_v;
        logic [63:0] rq_d[8];
        logic [1:0]  rq_f[8];
        logic        rq_fm[8];
        logic [2:0]  rq_rm[8];
        logic [63:0] held;
        logic stall_prev, saw_low;
        int sent, got, cyc, first, last;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 8; i++) begin
                rq_d[i] = rand_op();
                rq_f[i] = 2'($urandom);
                rq_fm[i] = 1'($urandom);
                rq_rm[i] = 3'($urandom_range(0, 4));
            end
            sb.delete();
            sent = 0;
            got = 0;
            cyc = 0;
            first = -1;
            last = -1;
            stall_prev = 1'b0;
            saw_low = 1'b0;
            held = '0;
            while (got < 8 && cyc < 100) begin
                @(negedge in_clk);
                in_ready = (ph == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
                in_valid = (sent < 8);
                in_data = rq_d[sent % 8];
                in_int_fmt = rq_f[sent % 8];
                in_fmt = rq_fm[sent % 8];
                in_rm = rq_rm[sent % 8];
                #1;
                if (stall_prev) begin
                    vectors++;
                    if (out_valid !== 1'b1 || out_data !== held) begin
                        miscompares++;
                        $display("FAIL b2b_stall_hold: valid=%b data=%h, want 1 %h",
                                 out_valid, out_data, held);
                    end
                end
                if (!out_ready) saw_low = 1'b1;
                if (in_valid && out_ready) begin
                    sb.push_back(ref_conv(in_data, in_int_fmt, in_fmt, in_rm));
                    sent++;
                end
                if (out_valid && in_ready) begin
                    if (first < 0) first = cyc;
                    last = cyc;
                    exp_v = sb.pop_front();
                    vectors++;
                    if (out_data !== exp_v[63:0] || out_flg_NX !== exp_v[64]) begin
                        miscompares++;
                        $display("FAIL b2b_result%0d: got %h nx=%b, want %h nx=%b",
                                 got, out_data, out_flg_NX, exp_v[63:0], exp_v[64]);
                    end
                    got++;
                end
                stall_prev = out_valid && !in_ready;
                held = out_data;
                cyc++;
            end
            in_valid = 1'b0;
            vectors++;
            if (got != 8) begin
                miscompares++;
                $display("FAIL b2b_count: got %0d results, want 8", got);
            end
            if (ph == 0) begin
                vectors++;
                if (first != 3 || last != 10) begin
                    miscompares++;
                    $display("FAIL b2b_throughput: results in cycles %0d..%0d, want 3..10",
                             first, last);
                end
            end else begin
                vectors++;
                if (saw_low !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready_drop: out_ready never 0, want a drop");
                end
            end
        end
    endtask

    task automatic test_reset_flush();
        int stale;
        @(negedge in_clk);
        in_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = rand_op();
            in_int_fmt = 2'($urandom);
            in_fmt = 1'($urandom);
            in_rm = 3'($urandom);
            @(negedge in_clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_fill: out_valid=%b, want 1", out_valid);
        end
        in_rst_n = 1'b0;
        @(negedge in_clk);
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_reset: valid=%b data=%h ready=%b, want 0 0 1",
                     out_valid, out_data, out_ready);
        end
        in_rst_n = 1'b1;
        in_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge in_clk);
            if (out_valid) stale++;
        end
        vectors++;
        if (stale != 0) begin
            miscompares++;
            $display("FAIL flush_stale: %0d stale results, want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int_fp_convert_pipe.md
Name: int_fp_convert_pipe

Overview:
- Pipelined integer-to-floating-point converter in the FP unit; the inverse path of the FP-to-integer converter (fcvt.s/d.w/wu/l/lu).
- Accepts a 32/64-bit signed/unsigned integer from the integer operand path and produces an IEEE-754 single or double result with correct rounding and an inexact flag for FP writeback.
- Three register stages with valid/ready handshakes on both sides.
- Full throughput: one conversion per cycle when the downstream stage does not stall.

Parameters:
- DATA_WIDTH, 64, operand/result width; fixed at 64 (only value supported).

Ports:
- in_clk  input  1  clock
- in_rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream holds a valid request
- out_ready  output  1  block can accept a request this cycle
- in_data  input  64  integer operand
- in_int_fmt  input  2  00=w signed 32, 01=wu unsigned 32, 10=l signed 64, 11=lu unsigned 64
- in_fmt  input  1  result format: 0=single, 1=double
- in_rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RNE
- out_valid  output  1  result valid
- in_ready  input  1  downstream accepts the result
- out_data  output  64  result; a single result is NaN-boxed as {32'hFFFFFFFF, single}
- out_flg_NX  output  1  inexact flag, qualified by out_valid

Behaviour:
- Reset (in_rst_n=0 at a clk edge):
  - All stage valid bits, out_valid, out_data and out_flg_NX clear to 0.
  - out_ready is 1 in the first cycle after reset.
  - Reset mid-operation flushes every in-flight conversion; nothing is emitted.
- Handshake:
  - A transfer occurs on a cycle with valid&ready on either side.
  - Each stage advances when the next stage is empty or is itself advancing.
  - out_ready = !s1_valid | s1_advance.
  - While out_valid=1 and in_ready=0, out_data and out_flg_NX hold stable.
  - Inputs are sampled only on an accepted cycle.
- Latency and throughput: 3 cycles from acceptance to out_valid with no stall; back-to-back accepts give back-to-back results.
- S1, operand capture:
  - 32-bit formats use in_data[31:0], sign-extended (w) or zero-extended (wu); in_data[63:32] is ignored.
  - Register sign = operand MSB for signed formats, else 0.
  - Register the 64-bit unsigned magnitude (two's complement negate when sign=1; -2^63 becomes magnitude 2^63), plus zero flag, in_fmt and in_rm.
- S2, normalize:
  - lz = leading-zero count of the magnitude.
  - Shift left by lz so bit 63 = 1.
  - Unbiased exponent e = 63 - lz.
- S3, round and pack:
  - Keep 53 (double) or 24 (single) bits including the hidden bit.
  - Guard = next bit; sticky = OR of the remaining bits.
  - NX = guard|sticky.
  - Increment when: RNE guard&(sticky|lsb); RTZ never; RDN sign&NX; RUP !sign&NX; RMM guard.
  - On mantissa carry-out: e+1, mantissa 0.
  - Biased exponent = e + 1023 (double) or e + 127 (single). Overflow cannot occur.
- Zero input gives +0.0 with NX=0; -0.0 is never produced.

Decomposition:
- Shared package fp_pkg:
  - Bias constants 1023/127.
  - Mantissa widths 52/23.
  - Rounding-mode encodings.
  - Integer-format encodings, shared with the FP-to-integer converter's output-format select.
  - The NaN-box constant.
- Sub-module lzc64: combinational 64-bit leading-zero counter, 7-bit output, 64 for all-zero input; instantiated in S2.

Test Plan:
- l 64'd1, double, RNE -> out_data=64'h3FF0000000000000, NX=0, out_valid exactly 3 cycles after accept.
- w 32'hFFFFFFFF (-1), single -> out_data=64'hFFFFFFFF_BF800000, NX=0; in_data[63:32]=random must not affect the result.
- wu 16777217 (2^24+1), single: RNE -> ...4B800000 NX=1; RUP -> ...4B800001 NX=1; RTZ -> ...4B800000 NX=1.
- lu 64'hFFFFFFFFFFFFFFFF, double, RNE -> 64'h43F0000000000000 (rounding carry), NX=1; l 64'h8000000000000000 -> 64'hC3E0000000000000, NX=0; zero -> 0, NX=0.
- Stream 8 back-to-back requests with in_ready toggled 1,0,0,1,...:
  - results arrive in order with none lost or duplicated;
  - out_data is stable during stalls;
  - out_ready drops to 0 once all three stages are full.
- Assert in_rst_n=0 with 3 conversions in flight -> next cycle out_valid=0, out_data=0, out_ready=1; no stale result after reset release.
